// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_G_CPU,
    S_G_DMA,
    S_DMA_TAIL,
    S_RELEASE
  } arb_state_e;

  localparam logic [1:0]  GNT_CPU  = 2'b01;
  localparam logic [1:0]  GNT_DMA  = 2'b10;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Wishbone bundle for the CPU, DMA and SDRAM sides of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [3:0]        cpu_sel_i;
  logic [ADDR_W-1:0] cpu_adr_i;
  logic [DATA_W-1:0] cpu_dat_i;
  logic              cpu_ack_o;
  logic [DATA_W-1:0] cpu_dat_o;

  logic              dma_cyc_i, dma_stb_i, dma_we_i, dma_fun_sel_i;
  logic [ADDR_W-1:0] dma_adr_i;
  logic              dma_ack_o, dma_burst_en_o;
  logic [DATA_W-1:0] dma_dat_o;

  logic              dram_cyc_o, dram_stb_o, dram_we_o, dram_fun_sel_o;
  logic [3:0]        dram_sel_o;
  logic [ADDR_W-1:0] dram_adr_o;
  logic [DATA_W-1:0] dram_dat_o;
  logic              dram_ack_i, dram_burst_en_i;
  logic [DATA_W-1:0] dram_dat_i;

  modport master (
    input  cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    output cpu_ack_o, cpu_dat_o,
    input  dma_cyc_i, dma_stb_i, dma_we_i, dma_fun_sel_i, dma_adr_i,
    output dma_ack_o, dma_burst_en_o, dma_dat_o,
    output dram_cyc_o, dram_stb_o, dram_we_o, dram_fun_sel_o, dram_sel_o,
    output dram_adr_o, dram_dat_o,
    input  dram_ack_i, dram_burst_en_i, dram_dat_i
  );

  modport slave (
    output cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    input  cpu_ack_o, cpu_dat_o,
    output dma_cyc_i, dma_stb_i, dma_we_i, dma_fun_sel_i, dma_adr_i,
    input  dma_ack_o, dma_burst_en_o, dma_dat_o,
    input  dram_cyc_o, dram_stb_o, dram_we_o, dram_fun_sel_o, dram_sel_o,
    input  dram_adr_o, dram_dat_o,
    output dram_ack_i, dram_burst_en_i, dram_dat_i
  );
endinterface

// File: rtl/sdram_arb_wdog.sv
// Grant watchdog: counts ack-less grant cycles, fires a one-cycle timeout
// and holds a sticky error until reset.
module sdram_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic timeout_o,
  output logic err_o
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_comb begin
    timeout_o = active_i && !ack_i && (cnt_q == LIMIT);
    cnt_d     = (!active_i || ack_i || timeout_o) ? 8'd0 : cnt_q + 8'd1;
    err_d     = err_q | timeout_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin Wishbone arbiter sharing one SDRAM port between CPU and DMA,
// with DMA burst forwarding. Define SDRAM_ARB_WDOG_EN to add the grant watchdog.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_WAIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  sdram_port_arbiter_if.master bus,
  output logic [1:0]           gnt_o,
  output logic                 err_o
);
  localparam logic [2:0] TAIL_LAST = 3'(BURST_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        last_gnt_q, last_gnt_d, owner_q, owner_d;
  logic [2:0]        tail_cnt_q, tail_cnt_d;
  logic              burst_seen_q, burst_seen_d;

  logic              cpu_pend, dma_pend, grant_active, wdog_to, err_dat_sel;
  logic              cyc, stb, we, fun, cpu_ack, dma_ack, burst;
  logic [1:0]        gnt;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdat, rd_dat;

  assign cpu_pend     = bus.cpu_cyc_i && bus.cpu_stb_i;
  assign dma_pend     = bus.dma_cyc_i && bus.dma_stb_i;
  assign grant_active = (state_q == S_G_CPU) || (state_q == S_G_DMA);

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    owner_d      = owner_q;
    tail_cnt_d   = tail_cnt_q;
    burst_seen_d = burst_seen_q;
    gnt = 2'b00; cyc = 1'b0; stb = 1'b0; we = 1'b0; fun = 1'b0;
    sel = 4'h0;  adr = '0;   wdat = '0;
    cpu_ack = 1'b0; dma_ack = 1'b0; burst = 1'b0; err_dat_sel = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie the requester that was not served last wins.
        if (cpu_pend && (!dma_pend || last_gnt_q == GNT_DMA)) begin
          state_d = S_G_CPU;
          owner_d = GNT_CPU;
        end else if (dma_pend) begin
          state_d = S_G_DMA;
          owner_d = GNT_DMA;
        end
      end
      S_G_CPU: begin
        gnt  = GNT_CPU;
        cyc  = bus.cpu_cyc_i;
        stb  = bus.cpu_stb_i;
        we   = bus.cpu_we_i;
        sel  = bus.cpu_sel_i;
        adr  = bus.cpu_adr_i;
        wdat = bus.cpu_dat_i;
        cpu_ack     = bus.cpu_cyc_i && (bus.dram_ack_i || wdog_to);
        err_dat_sel = wdog_to;
        if (!bus.cpu_cyc_i || bus.dram_ack_i || wdog_to) state_d = S_RELEASE;
      end
      S_G_DMA: begin
        gnt   = GNT_DMA;
        cyc   = bus.dma_cyc_i;
        stb   = bus.dma_stb_i;
        we    = bus.dma_we_i;
        fun   = bus.dma_fun_sel_i;
        sel   = 4'hF;
        adr   = bus.dma_adr_i;
        burst = bus.dram_burst_en_i;
        dma_ack     = bus.dma_cyc_i && (bus.dram_ack_i || wdog_to);
        err_dat_sel = wdog_to;
        if (!bus.dma_cyc_i) begin
          state_d = S_RELEASE;
        end else if (bus.dram_ack_i && !bus.dma_we_i && !wdog_to) begin
          state_d      = S_DMA_TAIL;
          tail_cnt_d   = 3'd0;
          burst_seen_d = 1'b0;
        end else if (bus.dram_ack_i || wdog_to) begin
          state_d = S_RELEASE;
        end
      end
      S_DMA_TAIL: begin
        gnt   = GNT_DMA;
        burst = bus.dram_burst_en_i;
        // Ends on the first low cycle after a burst, or when none starts in time.
        if (bus.dram_burst_en_i) begin
          burst_seen_d = 1'b1;
        end else if (burst_seen_q || tail_cnt_q == TAIL_LAST) begin
          state_d = S_RELEASE;
        end else begin
          tail_cnt_d = tail_cnt_q + 3'd1;
        end
      end
      S_RELEASE: begin
        last_gnt_d = owner_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      last_gnt_q   <= GNT_DMA;
      owner_q      <= 2'b00;
      tail_cnt_q   <= 3'd0;
      burst_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      owner_q      <= owner_d;
      tail_cnt_q   <= tail_cnt_d;
      burst_seen_q <= burst_seen_d;
    end
  end

`ifdef SDRAM_ARB_WDOG_EN
  sdram_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .active_i  (grant_active),
    .ack_i     (bus.dram_ack_i),
    .timeout_o (wdog_to),
    .err_o     (err_o)
  );
`else
  logic unused_wdog;
  assign unused_wdog = (^8'(TIMEOUT)) ^ grant_active;
  assign wdog_to     = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign rd_dat = err_dat_sel ? DATA_W'(ERR_DATA) : bus.dram_dat_i;

  assign gnt_o              = gnt;
  assign bus.dram_cyc_o     = cyc;
  assign bus.dram_stb_o     = stb;
  assign bus.dram_we_o      = we;
  assign bus.dram_fun_sel_o = fun;
  assign bus.dram_sel_o     = sel;
  assign bus.dram_adr_o     = adr;
  assign bus.dram_dat_o     = wdat;
  assign bus.cpu_ack_o      = cpu_ack;
  assign bus.dma_ack_o      = dma_ack;
  assign bus.dma_burst_en_o = burst;
  // Read data is blanked while reset is held so every output is quiet.
  assign bus.cpu_dat_o      = wb_rst_i ? '0 : rd_dat;
  assign bus.dma_dat_o      = wb_rst_i ? '0 : rd_dat;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed stimulus pushes expected
// grants and responses; a negedge monitor pops and compares them.
module tb_sdram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt_o;
  logic       err_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]  kind;  // 1 = cpu ack, 2 = dma ack, 3 = dma burst beat
    logic [31:0] dat;
  } rsp_t;

  rsp_t       rq[$];
  logic [1:0] gq[$];
  logic [1:0] prev_gnt = 2'b00;

  sdram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sdram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BURST_WAIT(4), .TIMEOUT(16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .gnt_o    (gnt_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_rsp(input logic [1:0] kind, input logic [31:0] dat, input string nm);
    rsp_t r;
    if (rq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: unexpected response kind %0d data %0h, none expected", nm, kind, dat);
    end else begin
      r = rq.pop_front();
      chk(nm, {30'd0, kind, dat}, {30'd0, r.kind, r.dat});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = 2'b00;
    end else begin
      if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
        if (gq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL grant_order: unexpected grant %b", gnt_o);
        end else begin
          chk("grant_order", {62'd0, gnt_o}, {62'd0, gq.pop_front()});
        end
      end
      prev_gnt = gnt_o;
      if (bus.cpu_ack_o)      pop_rsp(2'd1, bus.cpu_dat_o, "cpu_ack");
      if (bus.dma_ack_o)      pop_rsp(2'd2, bus.dma_dat_o, "dma_ack");
      if (bus.dma_burst_en_o) pop_rsp(2'd3, bus.dma_dat_o, "dma_burst");
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic clr_cpu();
    bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0; bus.cpu_we_i = 1'b0;
    bus.cpu_sel_i = 4'h0; bus.cpu_adr_i = '0;   bus.cpu_dat_i = '0;
  endtask

  task automatic clr_dma();
    bus.dma_cyc_i = 1'b0; bus.dma_stb_i = 1'b0; bus.dma_we_i = 1'b0;
    bus.dma_fun_sel_i = 1'b0; bus.dma_adr_i = '0;
  endtask

  task automatic cpu_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus.cpu_cyc_i = 1'b1; bus.cpu_stb_i = 1'b1; bus.cpu_we_i = we;
    bus.cpu_sel_i = 4'hF; bus.cpu_adr_i = adr; bus.cpu_dat_i = dat;
  endtask

  task automatic dma_req(input logic we, input logic fun, input logic [31:0] adr);
    bus.dma_cyc_i = 1'b1; bus.dma_stb_i = 1'b1; bus.dma_we_i = we;
    bus.dma_fun_sel_i = fun; bus.dma_adr_i = adr;
  endtask

  task automatic sdram_ack(input logic [1:0] kind, input logic [31:0] dat);
    bus.dram_ack_i = 1'b1;
    bus.dram_dat_i = dat;
    rq.push_back('{kind: kind, dat: dat});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_cpu();
    clr_dma();
    bus.dram_ack_i = 1'b0; bus.dram_burst_en_i = 1'b0;
    bus.dram_dat_i = 32'h1234_5678;
    repeat (2) tick();
    chk("rst_gnt", {62'd0, gnt_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_ctl", {59'd0, bus.dram_cyc_o, bus.dram_stb_o, bus.cpu_ack_o,
                    bus.dma_ack_o, bus.dma_burst_en_o}, 64'd0);
    chk("rst_dat", {bus.cpu_dat_o, bus.dma_dat_o}, 64'd0);
    chk("rst_adr", {32'd0, bus.dram_adr_o}, 64'd0);
    rst = 1'b0;
    bus.dram_dat_i = '0;
    tick();

    // CPU-only read, SDRAM acks three cycles after cyc
    gq.push_back(2'b01);
    cpu_req(1'b0, 32'h3800_0010, 32'h0);
    #1 chk("t1_gnt_latency", {62'd0, gnt_o}, 64'd0);
    tick();
    #1;
    chk("t1_gnt", {62'd0, gnt_o}, 64'd1);
    chk("t1_cyc", {63'd0, bus.dram_cyc_o}, 64'd1);
    chk("t1_adr", {32'd0, bus.dram_adr_o}, 64'h3800_0010);
    repeat (3) tick();
    sdram_ack(2'd1, 32'hCAFE_0001);
    tick();
    bus.dram_ack_i = 1'b0;
    clr_cpu();
    #1 chk("t1_release_cyc", {63'd0, bus.dram_cyc_o}, 64'd0);
    repeat (2) tick();

    // Simultaneous requests after reset: CPU, DMA, then CPU, DMA again
    do_reset();
    gq.push_back(2'b01); gq.push_back(2'b10);
    gq.push_back(2'b01); gq.push_back(2'b10);
    cpu_req(1'b1, 32'h10, 32'h99);
    dma_req(1'b1, 1'b0, 32'h100);
    tick();
    #1 chk("t2_wdat", {31'd0, bus.dram_we_o, bus.dram_dat_o}, {31'd0, 1'b1, 32'h99});
    sdram_ack(2'd1, 32'h11);
    tick();
    bus.dram_ack_i = 1'b0;
    clr_cpu();
    #1 chk("t2_gap_release", {63'd0, bus.dram_cyc_o}, 64'd0);
    tick();
    #1 chk("t2_gap_idle", {63'd0, bus.dram_cyc_o}, 64'd0);
    tick();
    #1 chk("t2_dma_adr", {32'd0, bus.dram_adr_o}, 64'h100);
    sdram_ack(2'd2, 32'h22);
    tick();
    bus.dram_ack_i = 1'b0;
    cpu_req(1'b0, 32'h20, 32'h0);
    repeat (2) tick();
    sdram_ack(2'd1, 32'h33);
    tick();
    bus.dram_ack_i = 1'b0;
    clr_cpu();
    repeat (2) tick();
    sdram_ack(2'd2, 32'h44);
    tick();
    bus.dram_ack_i = 1'b0;
    clr_dma();
    repeat (2) tick();

    // DMA read followed by a four-beat burst
    gq.push_back(2'b10);
    dma_req(1'b0, 1'b1, 32'h200);
    tick();
    #1 chk("t3_fun_sel", {63'd0, bus.dram_fun_sel_o}, 64'd1);
    sdram_ack(2'd2, 32'hA0);
    tick();
    bus.dram_ack_i = 1'b0;
    clr_dma();
    for (int i = 1; i <= 4; i++) begin
      bus.dram_burst_en_i = 1'b1;
      bus.dram_dat_i = 32'(i);
      rq.push_back('{kind: 2'd3, dat: 32'(i)});
      if (i == 1) #1 chk("t3_tail_cyc", {63'd0, bus.dram_cyc_o}, 64'd0);
      tick();
    end
    bus.dram_burst_en_i = 1'b0;
    bus.dram_dat_i = '0;
    #1 chk("t3_tail_end_gnt", {62'd0, gnt_o}, 64'd2);
    tick();
    #1 chk("t3_release", {61'd0, gnt_o, bus.dma_burst_en_o}, 64'd0);
    tick();

    // DMA read with no burst: four tail cycles then release
    gq.push_back(2'b10);
    dma_req(1'b0, 1'b0, 32'h204);
    tick();
    sdram_ack(2'd2, 32'hB0);
    tick();
    bus.dram_ack_i = 1'b0;
    clr_dma();
    repeat (3) tick();
    #1 chk("t4_tail4_gnt", {62'd0, gnt_o}, 64'd2);
    tick();
    #1 chk("t4_release_gnt", {62'd0, gnt_o}, 64'd0);
    repeat (2) tick();

    // CPU aborts two cycles into its grant; pending DMA goes next
    gq.push_back(2'b01); gq.push_back(2'b10);
    cpu_req(1'b0, 32'h40, 32'h0);
    tick();
    dma_req(1'b1, 1'b0, 32'h300);
    repeat (2) tick();
    clr_cpu();
    tick();
    #1 chk("t5_abort_cyc", {61'd0, gnt_o, bus.dram_cyc_o}, 64'd0);
    repeat (2) tick();
    #1 chk("t5_dma_adr", {32'd0, bus.dram_adr_o}, 64'h300);
    sdram_ack(2'd2, 32'h55);
    tick();
    bus.dram_ack_i = 1'b0;
    clr_dma();
    repeat (2) tick();

`ifdef SDRAM_ARB_WDOG_EN
    // No SDRAM ack: watchdog answers on the sixteenth grant cycle
    gq.push_back(2'b01);
    rq.push_back('{kind: 2'd1, dat: 32'hDEAD_BEEF});
    cpu_req(1'b0, 32'h50, 32'h0);
    repeat (16) tick();
    tick();
    #1 chk("t6_err_set", {63'd0, err_o}, 64'd1);
    clr_cpu();
    repeat (2) tick();
    #1 chk("t6_err_sticky", {63'd0, err_o}, 64'd1);
    tick();
`endif

    // Reset asserted while a burst is streaming
    gq.push_back(2'b10);
    dma_req(1'b0, 1'b0, 32'h400);
    tick();
    sdram_ack(2'd2, 32'hC0);
    tick();
    bus.dram_ack_i = 1'b0;
    bus.dram_burst_en_i = 1'b1;
    bus.dram_dat_i = 32'h77;
    #1 chk("t7_burst_live", {31'd0, bus.dma_burst_en_o, bus.dma_dat_o}, {31'd0, 1'b1, 32'h77});
    rst = 1'b1;
    #1;
    chk("t7_rst_ctl", {59'd0, gnt_o, bus.dram_cyc_o, bus.dma_burst_en_o, err_o}, 64'd0);
    chk("t7_rst_dat", {32'd0, bus.dma_dat_o}, 64'd0);
    tick();
    bus.dram_burst_en_i = 1'b0;
    bus.dram_dat_i = '0;
    clr_dma();
    rst = 1'b0;
    repeat (3) tick();

    chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
